// File: rtl/hazard_fwd_scoreboard.sv
// Hazard scoreboard beside the OF/EX register: shadows in-flight destinations for EX/MA/RW,
// produces per-source forwarding selects, the interlock stall, and a saturating stall counter.
module hazard_fwd_scoreboard #(
  parameter int NUM_REGS    = 16,
  parameter int REG_W       = 4,
  parameter int FORWARD     = 1,
  parameter int ZERO_REG_EN = 0,
  parameter int MULTI_LAT   = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             of_valid,
  input  logic [REG_W-1:0] of_src1,
  input  logic             of_src1_en,
  input  logic [REG_W-1:0] of_src2,
  input  logic             of_src2_en,
  input  logic [REG_W-1:0] of_dest,
  input  logic             of_dest_en,
  input  logic             of_is_load,
  input  logic             of_is_multi,
  input  logic             flush,
  output logic             stall,
  output logic             ex_busy,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MC_W = $clog2(MULTI_LAT) + 1;
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MULTI_LAT - 1);

  if ($clog2(NUM_REGS) != REG_W) begin : g_bad_reg_w
    $error("REG_W must equal clog2(NUM_REGS)");
  end

  // EX needs is_load for the load-use check; loads are forwardable from MA/RW, so those drop it.
  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] dest;
    logic             dest_en;
    logic             is_load;
  } ex_ent_t;

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] dest;
    logic             dest_en;
  } wb_ent_t;

  ex_ent_t          ex_p0_q, ex_p0_d;
  wb_ent_t          ma_p1_q, ma_p1_d;
  wb_ent_t          rw_p2_q, rw_p2_d;
  logic [MC_W-1:0]  mc_q, mc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic hit(input logic vld, input logic [REG_W-1:0] dest,
                               input logic dest_en, input logic [REG_W-1:0] src,
                               input logic src_en);
    logic zero_masked;
    zero_masked = (ZERO_REG_EN != 0) && (src == '0);
    return vld & dest_en & src_en & (dest == src) & ~zero_masked;
  endfunction

  function automatic logic [1:0] pick_src(input logic h_ex, input logic h_ma, input logic h_rw);
    if (h_ex)      return 2'd1;
    else if (h_ma) return 2'd2;
    else if (h_rw) return 2'd3;
    else           return 2'd0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic h_ex1, h_ma1, h_rw1, h_ex2, h_ma2, h_rw2;
  logic raw, ex_fwd_ok;

  always_comb begin
    h_ex1 = hit(ex_p0_q.vld, ex_p0_q.dest, ex_p0_q.dest_en, of_src1, of_src1_en);
    h_ma1 = hit(ma_p1_q.vld, ma_p1_q.dest, ma_p1_q.dest_en, of_src1, of_src1_en);
    h_rw1 = hit(rw_p2_q.vld, rw_p2_q.dest, rw_p2_q.dest_en, of_src1, of_src1_en);
    h_ex2 = hit(ex_p0_q.vld, ex_p0_q.dest, ex_p0_q.dest_en, of_src2, of_src2_en);
    h_ma2 = hit(ma_p1_q.vld, ma_p1_q.dest, ma_p1_q.dest_en, of_src2, of_src2_en);
    h_rw2 = hit(rw_p2_q.vld, rw_p2_q.dest, rw_p2_q.dest_en, of_src2, of_src2_en);

    ex_busy = (mc_q != '0);
    if (FORWARD != 0) raw = ex_p0_q.is_load & (h_ex1 | h_ex2);
    else              raw = h_ex1 | h_ma1 | h_rw1 | h_ex2 | h_ma2 | h_rw2;
    // A busy multi-cycle op holds the front end regardless of flush or OF validity.
    stall = ex_busy | (of_valid & ~flush & raw);

    ex_fwd_ok = ~ex_p0_q.is_load & ~ex_busy;
    if (FORWARD != 0) begin
      fwd_sel1 = pick_src(h_ex1 & ex_fwd_ok, h_ma1, h_rw1);
      fwd_sel2 = pick_src(h_ex2 & ex_fwd_ok, h_ma2, h_rw2);
    end else begin
      fwd_sel1 = 2'd0;
      fwd_sel2 = 2'd0;
    end
  end

  always_comb begin
    ex_p0_d = ex_p0_q;
    ma_p1_d = ma_p1_q;
    rw_p2_d = rw_p2_q;
    mc_d    = mc_q;
    cnt_d   = stall ? sat_inc(cnt_q) : cnt_q;

    rw_p2_d.vld     = ma_p1_q.vld;
    rw_p2_d.dest    = ma_p1_q.dest;
    rw_p2_d.dest_en = ma_p1_q.dest_en;

    if (ex_busy) begin
      mc_d        = mc_q - MC_W'(1);
      ma_p1_d.vld = 1'b0;
    end else begin
      ma_p1_d.vld     = ex_p0_q.vld;
      ma_p1_d.dest    = ex_p0_q.dest;
      ma_p1_d.dest_en = ex_p0_q.dest_en;
      if (stall) begin
        ex_p0_d.vld = 1'b0;
      end else begin
        ex_p0_d.vld     = of_valid & ~flush;
        ex_p0_d.dest    = of_dest;
        ex_p0_d.dest_en = of_dest_en;
        ex_p0_d.is_load = of_is_load;
        mc_d = (ex_p0_d.vld & of_is_multi & (MULTI_LAT > 1)) ? MC_LOAD : '0;
      end
    end
  end

  // Stage boundary: EX -> MA -> RW shadows; only control state is reset.
  always_ff @(posedge clk) begin
    ex_p0_q <= ex_p0_d;
    ma_p1_q <= ma_p1_d;
    rw_p2_q <= rw_p2_d;
    mc_q    <= mc_d;
    cnt_q   <= cnt_d;
    if (reset) begin
      ex_p0_q.vld <= 1'b0;
      ma_p1_q.vld <= 1'b0;
      rw_p2_q.vld <= 1'b0;
      mc_q        <= '0;
      cnt_q       <= '0;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Bench for hazard_fwd_scoreboard: a forwarding instance and an interlock-only instance share
// stimulus; a pipeline-occupancy model predicts both every cycle, plus directed literal checks.
module tb_hazard_fwd_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, of_valid, of_src1_en, of_src2_en, of_dest_en, of_is_load, of_is_multi, flush;
  logic [3:0] of_src1, of_src2, of_dest;
  logic        st0, bz0, st1, bz1;
  logic [1:0]  f10, f20, f11, f21;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  hazard_fwd_scoreboard #(.NUM_REGS(16), .REG_W(4), .FORWARD(1), .ZERO_REG_EN(1),
                          .MULTI_LAT(3), .CNT_W(16)) u_fwd (
    .clk(clk), .reset(reset), .of_valid(of_valid), .of_src1(of_src1), .of_src1_en(of_src1_en),
    .of_src2(of_src2), .of_src2_en(of_src2_en), .of_dest(of_dest), .of_dest_en(of_dest_en),
    .of_is_load(of_is_load), .of_is_multi(of_is_multi), .flush(flush), .stall(st0),
    .ex_busy(bz0), .fwd_sel1(f10), .fwd_sel2(f20), .stall_cycles(cnt0));

  hazard_fwd_scoreboard #(.NUM_REGS(16), .REG_W(4), .FORWARD(0), .ZERO_REG_EN(0),
                          .MULTI_LAT(1), .CNT_W(2)) u_ilk (
    .clk(clk), .reset(reset), .of_valid(of_valid), .of_src1(of_src1), .of_src1_en(of_src1_en),
    .of_src2(of_src2), .of_src2_en(of_src2_en), .of_dest(of_dest), .of_dest_en(of_dest_en),
    .of_is_load(of_is_load), .of_is_multi(of_is_multi), .flush(flush), .stall(st1),
    .ex_busy(bz1), .fwd_sel1(f11), .fwd_sel2(f21), .stall_cycles(cnt1));

  int npass = 0;
  int ntot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  // Model: per instance, the instruction occupying each of EX/MA/RW plus remaining busy cycles.
  typedef struct { bit v; int d; bit de; bit ld; } ment_t;
  ment_t m_st[2][3];
  int    m_busy[2];
  int    m_cnt[2];

  function automatic bit cfg_fwd(input int i); return i == 0; endfunction
  function automatic bit cfg_zr(input int i);  return i == 0; endfunction
  function automatic int cfg_lat(input int i); return (i == 0) ? 3 : 1; endfunction
  function automatic int cfg_max(input int i); return (i == 0) ? 65535 : 3; endfunction

  function automatic bit mhit(input int i, input int k, input int src, input bit en);
    return m_st[i][k].v && m_st[i][k].de && en && (m_st[i][k].d == src) &&
           !(cfg_zr(i) && src == 0);
  endfunction

  function automatic int pick(input int i, input bit a0, input bit a1, input bit a2, input bit bsy);
    if (a0 && !m_st[i][0].ld && !bsy) return 1;
    if (a1) return 2;
    if (a2) return 3;
    return 0;
  endfunction

  function automatic void mdl_eval(input int i, output bit stl, output bit bsy,
                                   output int s1, output int s2);
    bit a0, a1, a2, b0, b1, b2, haz;
    a0 = mhit(i, 0, int'(of_src1), of_src1_en);
    a1 = mhit(i, 1, int'(of_src1), of_src1_en);
    a2 = mhit(i, 2, int'(of_src1), of_src1_en);
    b0 = mhit(i, 0, int'(of_src2), of_src2_en);
    b1 = mhit(i, 1, int'(of_src2), of_src2_en);
    b2 = mhit(i, 2, int'(of_src2), of_src2_en);
    bsy = (m_busy[i] != 0);
    if (cfg_fwd(i)) haz = m_st[i][0].ld && (a0 || b0);
    else            haz = a0 || a1 || a2 || b0 || b1 || b2;
    stl = bsy || (of_valid && !flush && haz);
    s1 = cfg_fwd(i) ? pick(i, a0, a1, a2, bsy) : 0;
    s2 = cfg_fwd(i) ? pick(i, b0, b1, b2, bsy) : 0;
  endfunction

  always @(posedge clk) begin
    bit stl, bsy;
    int s1, s2;
    for (int i = 0; i < 2; i++) begin
      mdl_eval(i, stl, bsy, s1, s2);
      if (reset) begin
        for (int k = 0; k < 3; k++) m_st[i][k].v = 1'b0;
        m_busy[i] = 0;
        m_cnt[i]  = 0;
      end else begin
        if (stl && m_cnt[i] < cfg_max(i)) m_cnt[i]++;
        m_st[i][2] = m_st[i][1];
        if (bsy) begin
          m_busy[i]--;
          m_st[i][1].v = 1'b0;
        end else begin
          m_st[i][1] = m_st[i][0];
          if (stl) m_st[i][0].v = 1'b0;
          else begin
            m_st[i][0].v  = of_valid && !flush;
            m_st[i][0].d  = int'(of_dest);
            m_st[i][0].de = of_dest_en;
            m_st[i][0].ld = of_is_load;
            m_busy[i] = (m_st[i][0].v && of_is_multi && cfg_lat(i) > 1) ? cfg_lat(i) - 1 : 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    bit stl, bsy;
    int s1, s2;
    if (chk_en) begin
      mdl_eval(0, stl, bsy, s1, s2);
      chk("fwd.stall", st0, stl);
      chk("fwd.ex_busy", bz0, bsy);
      chk("fwd.fwd_sel1", f10, s1);
      chk("fwd.fwd_sel2", f20, s2);
      chk("fwd.stall_cycles", cnt0, m_cnt[0]);
      mdl_eval(1, stl, bsy, s1, s2);
      chk("ilk.stall", st1, stl);
      chk("ilk.ex_busy", bz1, bsy);
      chk("ilk.fwd_sel1", f11, s1);
      chk("ilk.fwd_sel2", f21, s2);
      chk("ilk.stall_cycles", cnt1, m_cnt[1]);
    end
  end

  task automatic drv(input bit v, input int s1, input bit e1, input int s2, input bit e2,
                     input int d, input bit de, input bit ld, input bit mc, input bit fl);
    of_valid = v;  of_src1 = 4'(s1); of_src1_en = e1; of_src2 = 4'(s2); of_src2_en = e2;
    of_dest = 4'(d); of_dest_en = de; of_is_load = ld; of_is_multi = mc; flush = fl;
  endtask

  task automatic nop();                drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input int d);      drv(1, 0, 0, 0, 0, d, 1, 0, 0, 0); endtask
  task automatic rd(input int s, input int d); drv(1, s, 1, 0, 0, d, 1, 0, 0, 0); endtask
  task automatic probe();              @(negedge clk); endtask
  task automatic tick();               @(posedge clk); #1; endtask
  task automatic do_reset();
    reset = 1'b1; nop(); tick(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    nop();
    @(posedge clk); #1;
    chk_en = 1'b1;
    probe();
    chk("rst.stall", st0, 0);     chk("rst.ex_busy", bz0, 0);
    chk("rst.sel1", f10, 0);      chk("rst.cnt", cnt0, 0);
    tick();
    reset = 1'b0;

    // add r3; add r4,r3,r5; then readers of r3 as the writer ages through MA, RW, retired
    do_reset();
    wr(3); probe(); chk("A.c1_stall", st0, 0); tick();
    drv(1, 3, 1, 5, 1, 4, 1, 0, 0, 0); probe();
    chk("A.ex_stall", st0, 0); chk("A.ex_sel1", f10, 1); chk("A.ex_sel2", f20, 0); tick();
    rd(3, 9); probe(); chk("A.ma_sel1", f10, 2); tick();
    rd(3, 9); probe(); chk("A.rw_sel1", f10, 3); tick();
    rd(3, 9); probe(); chk("A.rf_sel1", f10, 0); tick();

    // ld r2; sub r6,r2,r7 -> one load-use stall then forward from MA
    do_reset();
    probe(); chk("B.cnt_after_rst", cnt0, 0);
    drv(1, 0, 0, 0, 0, 2, 1, 1, 0, 0); tick();
    drv(1, 2, 1, 7, 1, 6, 1, 0, 0, 0); probe(); chk("B.lu_stall", st0, 1); tick();
    probe(); chk("B.post_stall", st0, 0); chk("B.ma_sel1", f10, 2); chk("B.cnt", cnt0, 1); tick();

    // multi r8 then consumer of r8: two busy cycles, then forward from EX
    do_reset();
    drv(1, 0, 0, 0, 0, 8, 1, 0, 1, 0); tick();
    rd(8, 10); probe(); chk("C.busy1", bz0, 1); chk("C.stall1", st0, 1); tick();
    probe(); chk("C.busy2", bz0, 1); chk("C.stall2", st0, 1); tick();
    probe(); chk("C.busy3", bz0, 0); chk("C.stall3", st0, 0); chk("C.ex_sel1", f10, 1);
    chk("C.cnt", cnt0, 2); tick();

    // multi r8 then an independent multi: stalls 2 cycles, then starts its own busy period
    do_reset();
    drv(1, 0, 0, 0, 0, 8, 1, 0, 1, 0); tick();
    drv(1, 1, 1, 0, 0, 9, 1, 0, 1, 0); probe(); chk("C2.stall1", st0, 1); tick();
    probe(); chk("C2.stall2", st0, 1); tick();
    probe(); chk("C2.stall3", st0, 0); tick();
    nop(); probe(); chk("C2.b2b_busy", bz0, 1); tick();

    // interlock-only instance: reader of r3 waits until the writer leaves RW; counter saturates at 3
    do_reset();
    wr(3); tick();
    rd(3, 9); probe(); chk("D.stall1", st1, 1); chk("D.sel1", f11, 0); tick();
    probe(); chk("D.stall2", st1, 1); tick();
    probe(); chk("D.stall3", st1, 1); tick();
    probe(); chk("D.stall4", st1, 0); chk("D.cnt", cnt1, 3); tick();
    rd(9, 10); probe(); chk("D.stall5", st1, 1); tick();
    probe(); chk("D.cnt_sat", cnt1, 3); tick();

    // r0 is never a hazard; flush kills a load-use consumer and leaves an EX bubble
    do_reset();
    wr(0); tick();
    drv(1, 0, 1, 0, 1, 5, 1, 0, 0, 0); probe();
    chk("E.r0_stall", st0, 0); chk("E.r0_sel1", f10, 0); chk("E.r0_sel2", f20, 0); tick();
    drv(1, 0, 0, 0, 0, 2, 1, 1, 0, 0); tick();
    drv(1, 2, 1, 0, 0, 6, 1, 0, 0, 1); probe(); chk("E.flush_stall", st0, 0); tick();
    drv(1, 6, 1, 2, 1, 7, 1, 0, 0, 0); probe();
    chk("E.bubble_sel1", f10, 0); chk("E.ld_ma_sel2", f20, 2); chk("E.stall", st0, 0); tick();

    // reset during a busy period discards the multi op and the counter
    do_reset();
    drv(1, 0, 0, 0, 0, 8, 1, 0, 1, 0); tick();
    nop(); reset = 1'b1; probe(); chk("F.busy_pre", bz0, 1); chk("F.stall_pre", st0, 1); tick();
    reset = 1'b0;
    rd(8, 9); probe();
    chk("F.busy", bz0, 0); chk("F.stall", st0, 0); chk("F.sel1", f10, 0); chk("F.cnt", cnt0, 0);
    tick();

    // mixed traffic over a small register window, checked only against the model
    for (int n = 0; n < 400; n++) begin
      drv(($urandom_range(9) < 8), $urandom_range(3), $urandom_range(1), $urandom_range(3),
          $urandom_range(1), $urandom_range(3), $urandom_range(1), ($urandom_range(3) == 0),
          ($urandom_range(6) == 0), ($urandom_range(9) == 0));
      reset = ($urandom_range(99) == 0);
      tick();
    end
    reset = 1'b0;
    nop();
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_scoreboard.md
Name: hazard_fwd_scoreboard

Overview:
- Parametrised successor to the combinational OF-stage interlock. Owns the pipeline's dest-register shadow, so hazard tracking is sequential.
- Tracks in-flight writes for the EX, MA and RW stages of the 4-stage back end (OF→EX→MA→RW).
- Generates per-source forwarding selects and a stall for load-use, multi-cycle EX ops and (mode-dependent) all RAW hazards. Also counts stall cycles.
- Sits beside the OF/EX pipeline register. Takes decoded OF fields, not raw IR.

Parameters:
- NUM_REGS, 16, architectural register count.
- REG_W, 4, register index width; must equal clog2(NUM_REGS).
- FORWARD, 1, 1 = forwarding mode; 0 = interlock-only mode (stall on any RAW match, no forwarding).
- ZERO_REG_EN, 0, 1 = register 0 is hard-wired zero and never creates a hazard.
- MULTI_LAT, 3, EX latency in cycles of a multi-cycle op (≥1; 1 = no busy period).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- of_valid  in  1  OF holds a real instruction
- of_src1  in  REG_W  source 1 index
- of_src1_en  in  1  source 1 is read
- of_src2  in  REG_W  source 2 index (store-data reg for stores)
- of_src2_en  in  1  source 2 is read
- of_dest  in  REG_W  destination index (ra for call)
- of_dest_en  in  1  instruction writes a register
- of_is_load  in  1  instruction is a load
- of_is_multi  in  1  instruction is multi-cycle in EX
- flush  in  1  branch taken: kill the OF instruction
- stall  out  1  hold PC/IF/OF; comb.
- ex_busy  out  1  multi-cycle op occupying EX; comb.
- fwd_sel1  out  2  src1 operand select: 0 RF, 1 EX, 2 MA, 3 RW; comb.
- fwd_sel2  out  2  src2 operand select, same encoding; comb.
- stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Clock and reset:
  - One clock domain; reset is synchronous and active-high.
  - Ports are named clk and reset, as elsewhere in the codebase.
- Reset:
  - All shadow valid bits are 0 and mc_cnt is 0.
  - stall_cycles is 0.
  - Outputs therefore read stall=0, ex_busy=0, fwd_sel1=fwd_sel2=0.
  - A reset mid-operation discards every in-flight entry, including a busy multi-cycle op.
- Shadow registers:
  - Stages X ∈ {EX, MA, RW}, each holding {valid, dest, dest_en, is_load}.
  - mc_cnt has width clog2(MULTI_LAT)+1.
- Match definition: match(X,s) = X.valid & X.dest_en & src_en & (X.dest==src), masked when ZERO_REG_EN & src==0.
- ex_busy = (mc_cnt != 0).
- Stall, FORWARD=1: stall = ex_busy | (EX.is_load & match(EX,src1 or src2)).
- Stall, FORWARD=0: stall = ex_busy | any match in EX/MA/RW on either source.
- Stall gating: stall is forced to 0 when !of_valid or flush, except that ex_busy still stalls.
- Forwarding selection, FORWARD=1, per source:
  - Priority is EX > MA > RW > RF.
  - EX is eligible only when !EX.is_load and !ex_busy.
  - A load in MA or RW is forwardable.
- Forwarding selection, FORWARD=0: fwd_sel is always 0.
- fwd_sel is driven even while stalled. The consumer ignores it.
- Stage advance on every clk edge, in priority order:
  1. ex_busy:
     - EX holds.
     - mc_cnt decrements.
     - MA receives a bubble (valid=0).
     - RW <= MA.
  2. Else stall (hazard):
     - EX receives a bubble.
     - MA <= EX.
     - RW <= MA.
  3. Else:
     - MA <= EX.
     - RW <= MA.
     - EX <= OF fields with valid = of_valid & !flush.
     - If that entry is of_is_multi and MULTI_LAT>1, mc_cnt <= MULTI_LAT-1.
- flush interactions:
  - flush while not busy kills the OF instruction and inserts a bubble.
  - flush takes priority over a hazard stall.
  - flush while ex_busy has no effect beyond the hold. OF is held anyway, and the kill is the IF/OF owner's job.
- Multi-cycle op result: the op is forwardable from EX only in its final EX cycle (mc_cnt==0). Before that, consumers stall.
- stall_cycles: increments by 1 on each cycle with stall=1 and saturates at all-ones.
- Simultaneous events:
  - A back-to-back multi op enters EX only after the previous op's mc_cnt reaches 0.
  - A load immediately followed by a multi consumer gives the load-use stall first, then the multi busy period.

Test Plan:
- FORWARD=1, `add r3` then dependent `add r4,r3,r5`: stall=0, fwd_sel1=1. Two cycles later with a gap, fwd_sel1=3; three cycles later, fwd_sel1=0.
- `ld r2` then `sub r6,r2,r7`: stall=1 for exactly 1 cycle, EX bubble, then fwd_sel1=2. stall_cycles=1.
- MULTI_LAT=3, multi op writing r8, then consumer of r8: ex_busy=1 for 2 cycles, stall=1 for 2 cycles, then fwd_sel from EX=1. Independent consumer still stalls 2 cycles.
- FORWARD=0, `add r3` then reader of r3: stall=1 for 3 cycles until RW retires, fwd_sel=0 throughout. stall_cycles=3.
- ZERO_REG_EN=1, writer of r0 then reader of r0 → stall=0, fwd_sel=0. Also: load-use hazard with flush=1 in the same cycle → stall=0 and EX bubble next cycle.
- Reset asserted during a multi-cycle busy period (mc_cnt=2) → next cycle ex_busy=0, stall=0, all shadows invalid, stall_cycles=0.
